// File: rtl/img_upscaler_nn.sv
// Nearest-neighbour upscaler. Each input row is buffered, then replayed with every
// pixel repeated 2^sx times and the whole row repeated 2^sy times.
module img_upscaler_nn #(
  parameter int RSZ_IMG_WIDTH_SIZE  = 32,
  parameter int RSZ_IMG_HEIGHT_SIZE = 32,
  parameter int PXL_PRIM_COLOR_NUM  = 1,
  parameter int PXL_PRIM_COLOR_W    = 8,
  parameter int SCALE_LOG2_MAX      = 5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start_i,
  input  logic [$clog2(SCALE_LOG2_MAX+1)-1:0]           scale_x_log2_i,
  input  logic [$clog2(SCALE_LOG2_MAX+1)-1:0]           scale_y_log2_i,
  output logic                                          busy_o,
  output logic                                          done_o,
  input  logic                                          s_valid_i,
  input  logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] s_data_i,
  output logic                                          s_ready_o,
  output logic                                          m_valid_o,
  output logic [PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W-1:0] m_data_o,
  output logic                                          m_sof_o,
  output logic                                          m_eol_o,
  output logic                                          m_eof_o,
  input  logic                                          m_ready_i
);

  localparam int W   = RSZ_IMG_WIDTH_SIZE;
  localparam int H   = RSZ_IMG_HEIGHT_SIZE;
  localparam int DW  = PXL_PRIM_COLOR_NUM * PXL_PRIM_COLOR_W;
  localparam int SW  = $clog2(SCALE_LOG2_MAX + 1);
  localparam int CXW = (W > 1) ? $clog2(W) : 1;
  localparam int RYW = (H > 1) ? $clog2(H) : 1;
  localparam int RW  = (SCALE_LOG2_MAX > 0) ? SCALE_LOG2_MAX : 1;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

  state_t state, stateNxt;

  logic [SW-1:0]  sx, sy, sxClamp, syClamp;
  logic [CXW-1:0] colIn, colOut;
  logic [RYW-1:0] rowIn;
  logic [RW-1:0]  repX, repY;
  logic [RW:0]    xSpan, ySpan;
  logic           xLast, yLast, colInLast, colOutLast, rowInLast, blockLast;
  logic           ld, doneR;

  logic [DW-1:0]  lineBuf [W];

  logic           mValid, mSof, mEol, mEof;
  logic [DW-1:0]  mData;

  assign sxClamp = (scale_x_log2_i > SW'(SCALE_LOG2_MAX)) ? SW'(SCALE_LOG2_MAX) : scale_x_log2_i;
  assign syClamp = (scale_y_log2_i > SW'(SCALE_LOG2_MAX)) ? SW'(SCALE_LOG2_MAX) : scale_y_log2_i;

  assign xSpan      = (RW+1)'(1) << sx;
  assign ySpan      = (RW+1)'(1) << sy;
  assign xLast      = ((RW+1)'(repX) == (xSpan - (RW+1)'(1)));
  assign yLast      = ((RW+1)'(repY) == (ySpan - (RW+1)'(1)));
  assign colInLast  = (colIn == CXW'(W - 1));
  assign colOutLast = (colOut == CXW'(W - 1));
  assign rowInLast  = (rowIn == RYW'(H - 1));
  assign blockLast  = xLast && colOutLast && yLast;

  // Output register refills whenever it is empty or its pixel is being taken.
  assign ld = (state == EMIT) && (!mValid || m_ready_i);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE: if (start_i) stateNxt = FILL;
      FILL: if (s_valid_i && colInLast) stateNxt = EMIT;
      EMIT: if (ld && blockLast) stateNxt = rowInLast ? DONE : FILL;
      DONE: if (!mValid || m_ready_i) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == FILL && s_valid_i) lineBuf[colIn] <= s_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sx     <= '0;
      sy     <= '0;
      colIn  <= '0;
      colOut <= '0;
      rowIn  <= '0;
      repX   <= '0;
      repY   <= '0;
      doneR  <= 1'b0;
      mValid <= 1'b0;
      mData  <= '0;
      mSof   <= 1'b0;
      mEol   <= 1'b0;
      mEof   <= 1'b0;
    end else begin
      doneR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            sx    <= sxClamp;
            sy    <= syClamp;
            rowIn <= '0;
            colIn <= '0;
          end
        end
        FILL: begin
          if (s_valid_i) begin
            if (colInLast) begin
              colIn  <= '0;
              colOut <= '0;
              repX   <= '0;
              repY   <= '0;
            end else begin
              colIn <= colIn + CXW'(1);
            end
          end
        end
        EMIT: begin
          // Odometer: repX innermost, then colOut, then repY, then the input row.
          if (ld) begin
            if (!xLast) begin
              repX <= repX + RW'(1);
            end else begin
              repX <= '0;
              if (!colOutLast) begin
                colOut <= colOut + CXW'(1);
              end else begin
                colOut <= '0;
                if (!yLast) begin
                  repY <= repY + RW'(1);
                end else begin
                  repY <= '0;
                  if (!rowInLast) rowIn <= rowIn + RYW'(1);
                end
              end
            end
          end
        end
        DONE: begin
          if (!mValid || m_ready_i) doneR <= 1'b1;
        end
        default: ;
      endcase

      if (ld) begin
        mValid <= 1'b1;
        mData  <= lineBuf[colOut];
        mSof   <= (rowIn == '0) && (repY == '0) && (colOut == '0) && (repX == '0);
        mEol   <= xLast && colOutLast;
        mEof   <= xLast && colOutLast && yLast && rowInLast;
      end else if (mValid && m_ready_i) begin
        mValid <= 1'b0;
      end
    end
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = doneR;
  assign s_ready_o = (state == FILL);
  assign m_valid_o = mValid;
  assign m_data_o  = mData;
  assign m_sof_o   = mSof;
  assign m_eol_o   = mEol;
  assign m_eof_o   = mEof;

endmodule

// File: tb/tb_img_upscaler_nn.sv
// Scoreboard bench for img_upscaler_nn on an 8x4 ramp image: expected output frames
// are queued at frame start and a negedge monitor pops and compares each handshake.
`timescale 1ns/1ps
module tb_img_upscaler_nn;

  localparam int W = 8;
  localparam int H = 4;
  localparam int LIMIT = 100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [2:0] scale_x_log2_i = '0;
  logic [2:0] scale_y_log2_i = '0;
  logic       busy_o, done_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o;
  logic       s_valid_i = 1'b0;
  logic [7:0] s_data_i = '0;
  logic [7:0] m_data_o;
  logic       m_ready_i = 1'b1;

  img_upscaler_nn #(
    .RSZ_IMG_WIDTH_SIZE (W),
    .RSZ_IMG_HEIGHT_SIZE(H),
    .PXL_PRIM_COLOR_NUM (1),
    .PXL_PRIM_COLOR_W   (8),
    .SCALE_LOG2_MAX     (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .scale_x_log2_i(scale_x_log2_i),
    .scale_y_log2_i(scale_y_log2_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .s_valid_i     (s_valid_i),
    .s_data_i      (s_data_i),
    .s_ready_o     (s_ready_o),
    .m_valid_o     (m_valid_o),
    .m_data_o      (m_data_o),
    .m_sof_o       (m_sof_o),
    .m_eol_o       (m_eol_o),
    .m_eof_o       (m_eof_o),
    .m_ready_i     (m_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sof, eol, eof, blk;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   doneCnt = 0;
  int   doneTarget = 0;
  int   outCnt = 0;
  bit   randReady = 0;
  bit   fullRate = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired, got timeout expected event at %0t", name, $time);
  endtask

  // Reference: output pixel (R,C) is input pixel (R>>sy, C>>sx) of the salted ramp.
  task automatic pushFrame(input int sx, input int sy, input int salt);
    exp_t e;
    int   rows = H << sy;
    int   cols = W << sx;
    int   repMask = (1 << sy) - 1;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        e.d   = 8'(((r >> sy) * W + (c >> sx) + salt) & 255);
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == cols - 1);
        e.eof = e.eol && (r == rows - 1);
        e.blk = e.eol && ((r & repMask) == repMask);
        q.push_back(e);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = randReady ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  logic [10:0] hold;
  bit          stallHeld = 0;
  bit          midBlock = 0;
  bit          prevBusy = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (rst) begin
      stallHeld = 0;
      midBlock  = 0;
      prevBusy  = 0;
    end else begin
      if (stallHeld)
        chk("stallHold", 32'({m_valid_o, m_data_o, m_sof_o, m_eol_o, m_eof_o}), 32'({1'b1, hold}));
      if (fullRate && midBlock)
        chk("fullRateValid", 32'(m_valid_o), 32'(1));
      if (m_valid_o && m_ready_i) begin
        if (q.size() == 0) begin
          chk("unexpectedPixel", 32'(m_data_o), 32'h100);
        end else begin
          e = q.pop_front();
          chk($sformatf("pixel%0d", outCnt), 32'({m_data_o, m_sof_o, m_eol_o, m_eof_o}),
              32'({e.d, e.sof, e.eol, e.eof}));
          if (!e.blk) chk("sReadyInEmit", 32'(s_ready_o), 32'(0));
          midBlock = !e.blk;
        end
        outCnt++;
      end
      stallHeld = m_valid_o && !m_ready_i;
      hold = {m_data_o, m_sof_o, m_eol_o, m_eof_o};
      if (done_o) begin
        doneCnt++;
        chk("doneBusyEdge", 32'({busy_o, prevBusy}), 32'({1'b0, 1'b1}));
        chk("doneQueueEmpty", 32'(q.size()), 32'(0));
      end
      prevBusy = busy_o;
    end
  end

  task automatic pulseStart(input logic [2:0] sxIn, input logic [2:0] syIn);
    @(posedge clk);
    #1;
    chk("idleBeforeStart", 32'(busy_o), 32'(0));
    start_i = 1'b1;
    scale_x_log2_i = sxIn;
    scale_y_log2_i = syIn;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busyAfterStart", 32'(busy_o), 32'(1));
  endtask

  task automatic sendRows(input int nRows, input int salt, input int gap, input bit lat, input bit stray);
    int t;
    for (int r = 0; r < nRows; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap > 0 && $urandom_range(99) < gap) begin
          s_valid_i = 1'b0;
          repeat ($urandom_range(3, 1)) begin
            @(posedge clk);
            #1;
          end
        end
        s_valid_i = 1'b1;
        s_data_i  = 8'((r * W + c + salt) & 255);
        if (stray && r == 0 && c == 3) begin
          start_i = 1'b1;
          scale_x_log2_i = 3'd3;
          scale_y_log2_i = 3'd3;
        end
        t = 0;
        while (!s_ready_o && t < LIMIT) begin
          @(posedge clk);
          #1;
          t++;
        end
        if (t >= LIMIT) begin
          flagFail("inputReady");
          s_valid_i = 1'b0;
          start_i = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
      end
      s_valid_i = 1'b0;
      if (lat) begin
        chk("latCycle1", 32'({m_valid_o, s_ready_o}), 32'(0));
        @(posedge clk);
        #1;
        chk("latCycle2", 32'(m_valid_o), 32'(1));
      end
    end
  endtask

  task automatic waitDone();
    int t = 0;
    doneTarget++;
    while (doneCnt < doneTarget && t < LIMIT) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= LIMIT) flagFail("doneWait");
    repeat (3) @(negedge clk);
    chk("doneOnce", 32'(doneCnt), 32'(doneTarget));
    @(posedge clk);
    #1;
  endtask

  task automatic runFrame(input logic [2:0] sxIn, input logic [2:0] syIn, input int expSx,
                          input int expSy, input int salt, input int gap, input bit lat,
                          input bit stray);
    pushFrame(expSx, expSy, salt);
    pulseStart(sxIn, syIn);
    sendRows(H, salt, gap, lat, stray);
    waitDone();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("resetOutputs", 32'({busy_o, done_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o, m_data_o}), 32'(0));

    runFrame(3'd0, 3'd0, 0, 0, 0, 0, 1'b1, 1'b0);   // passthrough
    runFrame(3'd1, 3'd2, 1, 2, 17, 0, 1'b0, 1'b0);
    runFrame(3'd5, 3'd5, 5, 5, 100, 0, 1'b0, 1'b0); // maximum scale
    runFrame(3'd7, 3'd0, 5, 0, 9, 0, 1'b0, 1'b0);   // clamps to 5

    fullRate = 0;
    randReady = 1;
    runFrame(3'd2, 3'd0, 2, 0, 50, 40, 1'b0, 1'b0);
    randReady = 0;
    @(posedge clk);
    #1;
    fullRate = 1;

    runFrame(3'd1, 3'd1, 1, 1, 33, 0, 1'b0, 1'b1);  // stray start ignored

    // Abort mid-EMIT of row 2, then a clean frame.
    pushFrame(1, 1, 77);
    pulseStart(3'd1, 3'd1);
    sendRows(3, 77, 0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("emitBeforeAbort", 32'({busy_o, m_valid_o}), 32'(3));
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abortOutputs", 32'({busy_o, done_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o, m_data_o}), 32'(0));
    repeat (10) @(posedge clk);
    #1;
    chk("abortNoDone", 32'(doneCnt), 32'(doneTarget));
    runFrame(3'd0, 3'd1, 0, 1, 200, 0, 1'b0, 1'b0);

    chk("allConsumed", 32'(q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got still running expected finished at %0t", $time);
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/img_upscaler_nn.md
Name: img_upscaler_nn

Overview:
- Nearest-neighbour upscaler. It is the inverse of the pooling resizer.
- Consumes a resized image stream (RSZ_IMG_WIDTH_SIZE x RSZ_IMG_HEIGHT_SIZE full-colour pixels, raster order).
- Emits an image enlarged by power-of-two factors: each pixel is replicated horizontally, each row vertically.
- Sits downstream of the resizer's serial pixel forwarder. Used for display/preview and for loopback checking of the resizer.

Parameters:
- RSZ_IMG_WIDTH_SIZE, 32, input image width in pixels (power of two)
- RSZ_IMG_HEIGHT_SIZE, 32, input image height in pixels (power of two)
- PXL_PRIM_COLOR_NUM, 1, primary colours per pixel
- PXL_PRIM_COLOR_W, 8, bits per primary colour
- SCALE_LOG2_MAX, 5, maximum log2 scale factor per axis (5 gives x32, restoring 1024 from 32)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- start_i, input, 1, frame start request; sampled only in IDLE
- scale_x_log2_i, input, $clog2(SCALE_LOG2_MAX+1), horizontal log2 factor; latched with start_i
- scale_y_log2_i, input, $clog2(SCALE_LOG2_MAX+1), vertical log2 factor; latched with start_i
- busy_o, output, 1, high from accepted start until frame end
- done_o, output, 1, one-cycle pulse after the last output pixel handshake
- s_valid_i, input, 1, input pixel valid
- s_data_i, input, PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W, input pixel (FcRszPxlData_t packing)
- s_ready_o, output, 1, input ready
- m_valid_o, output, 1, output pixel valid
- m_data_o, output, PXL_PRIM_COLOR_NUM*PXL_PRIM_COLOR_W, output pixel
- m_sof_o, output, 1, first pixel of output frame
- m_eol_o, output, 1, last pixel of each output row
- m_eof_o, output, 1, last pixel of output frame
- m_ready_i, input, 1, output ready

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - busy_o, done_o, s_ready_o, m_valid_o, m_sof_o, m_eol_o, m_eof_o = 0; m_data_o = 0.
  - State = IDLE; all counters = 0.
  - Line buffer contents are don't-care.
- Handshakes:
  - Transfer occurs on valid&ready at a rising edge.
  - m_valid_o, once high, holds with m_data_o and the flag outputs stable until m_ready_i.
  - m_valid_o does not depend combinationally on m_ready_i.
- FSM:
  - IDLE: if start_i, latch sx = scale_x_log2_i and sy = scale_y_log2_i, clear row_in and go to FILL. start_i in any other state is ignored.
  - FILL: s_ready_o = 1. Each accepted pixel is written to linebuf[col_in] and col_in increments. On acceptance at col_in = RSZ_IMG_WIDTH_SIZE-1, go to EMIT with rep_y = col_out = rep_x = 0.
  - EMIT:
    - s_ready_o = 0.
    - The output register loads linebuf[col_out] whenever it is empty or handshaking.
    - Counter order, innermost first: rep_x (0..2^sx-1), then col_out (0..W-1), then rep_y (0..2^sy-1).
    - After the final rep_y wraps: if row_in = RSZ_IMG_HEIGHT_SIZE-1, go to DONE; else increment row_in and go to FILL.
  - DONE: wait for the last output handshake, pulse done_o for 1 cycle, return to IDLE. busy_o falls in the same cycle as the done_o pulse.
- Latency:
  - The first output pixel of a row is valid in the 2nd cycle after the row's last input acceptance (1 cycle for the FSM transition, 1 cycle for the output register).
  - With m_ready_i held high, output is 1 pixel/cycle for the whole row block.
- Output flags (asserted with the pixel they describe):
  - m_sof_o: row_in = 0, rep_y = 0, col_out = 0, rep_x = 0.
  - m_eol_o: col_out = W-1 and rep_x = 2^sx-1.
  - m_eof_o: m_eol_o plus the last rep_y of the last row_in.
- Output size: (W<<sx) x (H<<sy). Output pixel (r,c) equals input pixel (r>>sy, c>>sx).
- Scale bounds: scale values > SCALE_LOG2_MAX are clamped to SCALE_LOG2_MAX at latch. sx = sy = 0 is passthrough with the row-buffered latency above.
- Throughput: there is no FILL/EMIT overlap, so input stalls during EMIT. This is accepted.
- Reset mid-frame: rst in any state returns to IDLE on the next edge. A partial frame is discarded, outputs drop to reset values, and no done_o is issued.

Test Plan:
- sx=sy=0, 32x32 ramp input (pixel = row*32+col mod 256), m_ready_i=1 -> 1024 outputs equal to input order; m_sof_o on output 0, m_eol_o every 32nd, m_eof_o on output 1023; done_o pulses once.
- sx=1, sy=2, same ramp -> 64x128 = 8192 outputs; out(r,c) = in(r>>2, c>>1); 128 m_eol_o pulses; s_ready_o = 0 throughout each EMIT.
- sx=sy=5 -> 1024x1024 outputs; spot-check (1023,1023) = in(31,31) with m_eof_o = 1; busy_o high until done_o.
- sx=2, sy=0, random m_ready_i (50%) and random s_valid_i gaps -> m_data_o and flags stable while stalled; no pixel lost or duplicated versus the reference model.
- start_i pulsed during FILL with scale 3/3 after starting with 1/1 -> ignored; output stays 64x64.
- rst asserted mid-EMIT of row 5 -> next cycle m_valid_o = 0, busy_o = 0, s_ready_o = 0; a new start runs a clean full frame with no done_o from the aborted frame.
